fe_event_packer: RTL

FE_EVENT_PACKER -- requirements
Module: fe_event_packer

---
 rtl/fe_event_packer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fe_event_packer.sv
// Front-end event packer: timestamps DATA/STAT events into cmd-tagged words and
// queues up to three words per cycle toward a downstream FIFO.
module fe_event_packer #(
    parameter int pDATA_W  = 8,
    parameter int pSTAT_W  = 5,
    parameter int pSHORT_W = 3,
    parameter int pFULL_W  = 16,
    parameter int pQDEPTH  = 8
) (
    input  logic                 fe_clk,
    input  logic                 reset_n,
    input  logic                 capture_en,
    input  logic                 timestamps_disable,
    input  logic [15:0]          max_events,
    input  logic                 fe_rxvalid,
    input  logic [pDATA_W-1:0]   fe_data,
    input  logic [pSTAT_W-1:0]   fe_stat,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [pFULL_W+1:0]   fifo_din,
    output logic                 capturing,
    output logic                 done,
    output logic                 overflow
);

    localparam int AW     = $clog2(pQDEPTH);
    localparam int CW     = AW + 1;
    localparam int WORD_W = pFULL_W + 2;
    localparam int EV_W   = pDATA_W + pSTAT_W + pSHORT_W;

    localparam logic [1:0] CMD_DATA = 2'b00;
    localparam logic [1:0] CMD_STAT = 2'b01;
    localparam logic [1:0] CMD_TIME = 2'b10;
    localparam logic [1:0] CMD_OVF  = 2'b11;

    localparam logic [pFULL_W-1:0] FULLMAX  = '1;
    localparam logic [pFULL_W-1:0] SHORTMAX = pFULL_W'((1 << pSHORT_W) - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [pFULL_W-1:0] pack_event(
        input logic [pDATA_W-1:0]  d,
        input logic [pSTAT_W-1:0]  s,
        input logic [pSHORT_W-1:0] t
    );
        logic [pFULL_W-1:0] p;
        p = '0;
        p[EV_W-1:0] = {d, s, t};
        return p;
    endfunction

    logic                 cap_en_q, capturing_q, done_q, ovf_q;
    logic [pSTAT_W-1:0]   stat_q;
    logic [pFULL_W-1:0]   delta_q, delta_d;
    logic [7:0]           drop_q, drop_d;
    logic [15:0]          evcnt_q, evcnt_d;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d, free;
    logic [WORD_W-1:0]    mem_q [pQDEPTH];

    logic                 start, active, is_data, is_stat, is_event;
    logic                 need_time_ev, need_time_idle, ovf_pend, pop;
    logic                 fits, accept, drop, hit;
    logic [1:0]           n_req, n_push;
    logic [pSHORT_W-1:0]  short_t;
    logic [WORD_W-1:0]    words [4];

    // Event classification; arming needs a fresh 0->1 edge of capture_en.
    assign start          = capture_en & ~cap_en_q;
    assign active         = capturing_q & capture_en;
    assign is_data        = active & fe_rxvalid;
    assign is_stat        = active & ~fe_rxvalid & (fe_stat != stat_q);
    assign is_event       = is_data | is_stat;
    assign need_time_ev   = is_event & ~timestamps_disable & (delta_q > SHORTMAX);
    assign need_time_idle = active & ~is_event & ~timestamps_disable & (delta_q == FULLMAX);
    assign ovf_pend       = (drop_q != 8'd0) & ~start;
    assign pop            = (count_q != '0) & ~fifo_full;
    assign free           = CW'(pQDEPTH) - count_q + CW'(pop);
    assign short_t        = (timestamps_disable || delta_q > SHORTMAX) ? '0 : delta_q[pSHORT_W-1:0];

    always_comb begin
        words[0] = '0;
        words[1] = '0;
        words[2] = '0;
        words[3] = '0;
        n_req    = 2'd0;
        if (ovf_pend) begin
            words[n_req] = {CMD_OVF, pFULL_W'(drop_q)};
            n_req        = n_req + 2'd1;
        end
        if (need_time_ev || need_time_idle) begin
            words[n_req] = {CMD_TIME, delta_q};
            n_req        = n_req + 2'd1;
        end
        if (is_event) begin
            words[n_req] = {is_data ? CMD_DATA : CMD_STAT,
                            pack_event(is_data ? fe_data : '0, fe_stat, short_t)};
            n_req        = n_req + 2'd1;
        end
        fits   = (CW'(n_req) <= free);
        accept = (n_req != 2'd0) & fits;
        drop   = (is_event | need_time_idle) & ~fits;
        n_push = accept ? n_req : 2'd0;
    end

    always_comb begin
        delta_d = delta_q;
        if (start || (active && timestamps_disable)) begin
            delta_d = '0;
        end else if (active) begin
            if (is_event) begin
                delta_d = accept ? '0 : delta_q;
            end else if (need_time_idle) begin
                delta_d = accept ? pFULL_W'(1) : delta_q;
            end else begin
                delta_d = delta_q + pFULL_W'(1);
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (start)
            drop_d = 8'd0;
        else if (drop)
            drop_d = sat_inc8(drop_q);
        else if (accept && ovf_pend)
            drop_d = 8'd0;
    end

    assign evcnt_d = start ? 16'd0 : ((is_event && accept) ? evcnt_q + 16'd1 : evcnt_q);
    assign hit     = is_event & accept & (max_events != 16'd0) & (evcnt_q + 16'd1 == max_events);
    assign count_d = count_q + CW'(n_push) - CW'(pop);

    // Control and queue-pointer state.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_en_q    <= 1'b1;
            capturing_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            stat_q      <= '0;
            delta_q     <= '0;
            drop_q      <= 8'd0;
            evcnt_q     <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            cap_en_q <= capture_en;
            if (start)
                capturing_q <= 1'b1;
            else if (!capture_en || hit)
                capturing_q <= 1'b0;
            if (start)
                done_q <= 1'b0;
            else if (hit)
                done_q <= 1'b1;
            if (start)
                ovf_q <= 1'b0;
            else if (drop)
                ovf_q <= 1'b1;
            if (start)
                stat_q <= '0;
            else if (active)
                stat_q <= fe_stat;
            delta_q  <= delta_d;
            drop_q   <= drop_d;
            evcnt_q  <= evcnt_d;
            wr_ptr_q <= wr_ptr_q + AW'(n_push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
        end
    end

    // Word storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge fe_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (i < int'(n_push))
                mem_q[wr_ptr_q + AW'(i)] <= words[i];
        end
    end

    assign fifo_wr   = pop;
    assign fifo_din  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign capturing = capturing_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule
